// File: rtl/axi_lite_regfile.sv
// axi_lite_regfile
//   AXI4-Lite slave register file. Holds NUM_REGS 32-bit registers at
//   BASE_ADDR + 4*i. It exports every register and a one-cycle write pulse
//   per register to downstream logic.
//
//   Optional feature macro: AXIL_REGFILE_SLVERR_EN
//     defined   : out-of-range accesses answer SLVERR (2'b10).
//     undefined : every access answers OKAY (2'b00).
//
//   Ports
//     aclk, areset            clock (posedge) / async active-high reset
//     aw*, w*, b*             write address / data / response channels
//     ar*, r*                 read address / data channels
//     reg_out                 register i on [32i+31:32i]
//     wr_pulse                bit i pulses for one cycle when register i is written
//
//   Handshake: a transfer happens on a rising edge where valid and ready are
//   both high. Once raised, the slave holds bvalid/bresp and rvalid/rdata/rresp
//   stable until the matching ready is seen. All outputs come from flops.
module axi_lite_regfile #(
  parameter int unsigned NUM_REGS    = 8,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter logic [31:0] RESET_VALUE = 32'h0000_0000
) (
  input  logic                     aclk,
  input  logic                     areset,
  input  logic [31:0]              awaddr,
  input  logic [2:0]               awprot,
  input  logic                     awvalid,
  output logic                     awready,
  input  logic [31:0]              wdata,
  input  logic [3:0]               wstrb,
  input  logic                     wvalid,
  output logic                     wready,
  output logic [1:0]               bresp,
  output logic                     bvalid,
  input  logic                     bready,
  input  logic [31:0]              araddr,
  input  logic [2:0]               arprot,
  input  logic                     arvalid,
  output logic                     arready,
  output logic [31:0]              rdata,
  output logic [1:0]               rresp,
  output logic                     rvalid,
  input  logic                     rready,
  output logic [32*NUM_REGS-1:0]   reg_out,
  output logic [NUM_REGS-1:0]      wr_pulse
);

  localparam int unsigned IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [31:0] SPAN  = 32'(4 * NUM_REGS);
  localparam logic [1:0]  RESP_OKAY = 2'b00;
`ifdef AXIL_REGFILE_SLVERR_EN
  localparam logic [1:0]  RESP_MISS = 2'b10;
`else
  localparam logic [1:0]  RESP_MISS = 2'b00;
`endif

  typedef enum logic { W_IDLE, W_RESP } w_state_t;
  typedef enum logic { R_IDLE, R_DATA } r_state_t;

  w_state_t w_state, w_next;
  r_state_t r_state, r_next;

  logic [31:0] regs [NUM_REGS];

  // Write holding registers: AW and W are captured independently.
  logic        aw_held, w_held;
  logic [31:0] aw_addr_q, w_data_q;
  logic [3:0]  w_strb_q;

  // Decode: the subtraction wraps, so addresses below BASE_ADDR land far out
  // of range and miss.
  logic [31:0]      w_off, r_off;
  logic             w_hit, r_hit;
  logic [IDX_W-1:0] w_idx, r_idx;

  assign w_off = aw_addr_q - BASE_ADDR;
  assign w_hit = (w_off < SPAN);
  assign w_idx = w_off[IDX_W+1:2];
  assign r_off = araddr - BASE_ADDR;
  assign r_hit = (r_off < SPAN);
  assign r_idx = r_off[IDX_W+1:2];

  // Protection bits carry no meaning for this slave.
  logic unused_prot;
  assign unused_prot = ^{awprot, arprot};

  // ---------------- write FSM ----------------
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) w_state <= W_IDLE;
    else        w_state <= w_next;
  end

  always_comb begin
    w_next = w_state;
    case (w_state)
      W_IDLE: if (aw_held && w_held) w_next = W_RESP;
      W_RESP: if (bready)            w_next = W_IDLE;
      default: w_next = W_IDLE;
    endcase
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      awready   <= 1'b0;
      wready    <= 1'b0;
      bvalid    <= 1'b0;
      bresp     <= RESP_OKAY;
      aw_held   <= 1'b0;
      w_held    <= 1'b0;
      aw_addr_q <= '0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
      wr_pulse  <= '0;
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= RESET_VALUE;
    end else begin
      wr_pulse <= '0;
      case (w_state)
        W_IDLE: begin
          if (aw_held && w_held) begin
            aw_held <= 1'b0;
            w_held  <= 1'b0;
            bvalid  <= 1'b1;
            bresp   <= w_hit ? RESP_OKAY : RESP_MISS;
            if (w_hit) begin
              for (int k = 0; k < 4; k++)
                if (w_strb_q[k]) regs[w_idx][8*k +: 8] <= w_data_q[8*k +: 8];
              wr_pulse[w_idx] <= 1'b1;
            end
          end else begin
            if (awvalid && awready) begin
              aw_addr_q <= awaddr;
              aw_held   <= 1'b1;
            end
            if (wvalid && wready) begin
              w_data_q <= wdata;
              w_strb_q <= wstrb;
              w_held   <= 1'b1;
            end
            // Ready stays low from capture until the response completes;
            // this also raises it on the first edge after reset.
            awready <= !(aw_held || (awvalid && awready));
            wready  <= !(w_held  || (wvalid  && wready));
          end
        end
        W_RESP: begin
          if (bready) begin
            bvalid  <= 1'b0;
            awready <= 1'b1;
            wready  <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // ---------------- read FSM ----------------
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) r_state <= R_IDLE;
    else        r_state <= r_next;
  end

  always_comb begin
    r_next = r_state;
    case (r_state)
      R_IDLE: if (arvalid && arready) r_next = R_DATA;
      R_DATA: if (rready)             r_next = R_IDLE;
      default: r_next = R_IDLE;
    endcase
  end

  // Sampling regs on the same edge as a write returns the pre-write value.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      arready <= 1'b0;
      rvalid  <= 1'b0;
      rdata   <= '0;
      rresp   <= RESP_OKAY;
    end else begin
      case (r_state)
        R_IDLE: begin
          if (arvalid && arready) begin
            rdata   <= r_hit ? regs[r_idx] : 32'h0;
            rresp   <= r_hit ? RESP_OKAY : RESP_MISS;
            rvalid  <= 1'b1;
            arready <= 1'b0;
          end else begin
            arready <= 1'b1;
          end
        end
        R_DATA: begin
          if (rready) begin
            rvalid  <= 1'b0;
            arready <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_out
    assign reg_out[32*g +: 32] = regs[g];
  end

endmodule

// File: tb/tb_axi_lite_regfile.sv
// tb_axi_lite_regfile
//   Directed and randomized bench for axi_lite_regfile with a behavioural
//   register model. Inputs change on the falling edge; outputs are observed
//   on the falling edge.
module tb_axi_lite_regfile;

  localparam int          NR    = 8;
  localparam logic [31:0] BASE  = 32'h0000_0000;
  localparam logic [31:0] RST_V = 32'h0000_0000;
  localparam int          TMO   = 100;

  logic            aclk = 1'b0;
  logic            areset;
  logic [31:0]     awaddr, wdata, araddr;
  logic [2:0]      awprot, arprot;
  logic            awvalid, wvalid, bready, arvalid, rready;
  logic [3:0]      wstrb;
  logic            awready, wready, bvalid, arready, rvalid;
  logic [1:0]      bresp, rresp;
  logic [31:0]     rdata;
  logic [32*NR-1:0] reg_out;
  logic [NR-1:0]   wr_pulse;

  axi_lite_regfile #(.NUM_REGS(NR), .BASE_ADDR(BASE), .RESET_VALUE(RST_V)) dut (
    .aclk(aclk), .areset(areset),
    .awaddr(awaddr), .awprot(awprot), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .araddr(araddr), .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .reg_out(reg_out), .wr_pulse(wr_pulse)
  );

  // ---------------- clock / reset ----------------
  always #5 aclk = ~aclk;

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  // ---------------- model / scoreboard ----------------
  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] model [NR];
  int exp_pulse [NR];
  int pulse_cnt [NR];
  logic [31:0] exp_q [$];

  always @(negedge aclk)
    if (!areset)
      for (int i = 0; i < NR; i++) if (wr_pulse[i]) pulse_cnt[i]++;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic timeout(input string tag);
    n_cmp++;
    n_err++;
    $error("FAIL %s timeout observed=none expected=handshake", tag);
  endtask

  function automatic logic in_range(input logic [31:0] a);
    longint unsigned off;
    off = longint'(a - BASE);
    return off < 4 * NR;
  endfunction

  function automatic logic [1:0] exp_resp(input logic [31:0] a);
`ifdef AXIL_REGFILE_SLVERR_EN
    return in_range(a) ? 2'b00 : 2'b10;
`else
    return (a == a) ? 2'b00 : 2'b00;
`endif
  endfunction

  function automatic logic [31:0] model_read(input logic [31:0] a);
    if (!in_range(a)) return 32'h0;
    return model[(a - BASE) / 4];
  endfunction

  task automatic model_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] mask;
    int idx;
    if (in_range(a)) begin
      idx  = int'((a - BASE) / 4);
      mask = 32'h0;
      for (int k = 0; k < 4; k++) if (s[k]) mask = mask | (32'hFF << (8 * k));
      model[idx] = (model[idx] & ~mask) | (d & mask);
      exp_pulse[idx]++;
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NR; i++) model[i] = RST_V;
  endtask

  task automatic chk_regs(input string tag);
    for (int i = 0; i < NR; i++) chk($sformatf("%s_reg%0d", tag, i), reg_out[32*i +: 32], model[i]);
  endtask

  task automatic chk_pulses(input string tag);
    for (int i = 0; i < NR; i++) chk($sformatf("%s_pulse%0d", tag, i), pulse_cnt[i], exp_pulse[i]);
  endtask

  // ---------------- driver tasks ----------------
  task automatic axi_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                           input int aw_dly, input int w_dly, input int b_dly);
    fork
      begin
        int n = 0;
        repeat (aw_dly) @(negedge aclk);
        awaddr = a; awvalid = 1'b1;
        while (!awready && n < TMO) begin @(negedge aclk); n++; end
        if (n >= TMO) timeout("aw");
        @(negedge aclk);
        awvalid = 1'b0;
      end
      begin
        int n = 0;
        repeat (w_dly) @(negedge aclk);
        wdata = d; wstrb = s; wvalid = 1'b1;
        while (!wready && n < TMO) begin @(negedge aclk); n++; end
        if (n >= TMO) timeout("w");
        @(negedge aclk);
        wvalid = 1'b0;
      end
    join
    // Both halves are now held; the write lands on the next edge.
    chk("b_early", bvalid, 1'b0);
    @(negedge aclk);
    chk("b_lat", bvalid, 1'b1);
    chk("bresp", bresp, exp_resp(a));
    model_write(a, d, s);
    chk_regs("wr");
    for (int c = 0; c < b_dly; c++) begin
      @(negedge aclk);
      chk("b_hold", {bvalid, bresp}, {1'b1, exp_resp(a)});
      chk("aw_w_blocked", {awready, wready}, 2'b00);
    end
    bready = 1'b1;
    @(negedge aclk);
    bready = 1'b0;
    chk("b_done", bvalid, 1'b0);
    chk("aw_w_back", {awready, wready}, 2'b11);
    chk_pulses("wr");
  endtask

  task automatic axi_read(input logic [31:0] a, input int r_dly,
                          output logic [31:0] d, output logic [1:0] rr);
    int n = 0;
    araddr = a; arvalid = 1'b1;
    while (!arready && n < TMO) begin @(negedge aclk); n++; end
    if (n >= TMO) timeout("ar");
    @(negedge aclk);
    arvalid = 1'b0;
    chk("r_lat", rvalid, 1'b1);
    d  = rdata;
    rr = rresp;
    for (int c = 0; c < r_dly; c++) begin
      @(negedge aclk);
      chk("r_hold", {rvalid, arready, rresp, rdata}, {1'b1, 1'b0, rr, d});
    end
    rready = 1'b1;
    @(negedge aclk);
    rready = 1'b0;
    chk("r_done", {rvalid, arready}, 2'b01);
  endtask

  task automatic read_chk(input logic [31:0] a, input int r_dly);
    logic [31:0] d;
    logic [1:0]  rr;
    exp_q.push_back(model_read(a));
    axi_read(a, r_dly, d, rr);
    chk("rdata", d, exp_q.pop_front());
    chk("rresp", rr, exp_resp(a));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] d5;
    logic [1:0]  r5;
    logic [31:0] a, d;
    logic [3:0]  s;

    areset = 1'b1;
    awaddr = '0; wdata = '0; araddr = '0; awprot = 3'b010; arprot = 3'b101;
    awvalid = 1'b0; wvalid = 1'b0; bready = 1'b0; arvalid = 1'b0; rready = 1'b0;
    wstrb = '0;
    for (int i = 0; i < NR; i++) begin exp_pulse[i] = 0; pulse_cnt[i] = 0; end
    model_reset();
    repeat (3) @(negedge aclk);
    areset = 1'b0;

    // Reset state, then readiness on the first edge after release.
    chk("rst_ready", {awready, wready, arready}, 3'b000);
    chk("rst_valid", {bvalid, rvalid}, 2'b00);
    chk("rst_resp", {bresp, rresp}, 4'b0000);
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_pulse", wr_pulse, '0);
    chk_regs("rst");
    @(negedge aclk);
    chk("first_ready", {awready, wready, arready}, 3'b111);
    for (int i = 0; i < NR; i++) read_chk(BASE + 4 * i, 0);

    // AW first, W three cycles later.
    axi_write(BASE + 32'h8, 32'hDEADBEEF, 4'hF, 0, 3, 2);
    chk("t2_reg2", reg_out[95:64], 32'hDEADBEEF);

    // Partial strobes.
    axi_write(BASE + 32'h4, 32'hFFFFFFFF, 4'hF, 0, 0, 0);
    axi_write(BASE + 32'h4, 32'h12345678, 4'h5, 1, 0, 1);
    chk("t3_reg1", reg_out[63:32], 32'hFF34FF78);
    read_chk(BASE + 32'h4, 1);

    // Zero strobe still pulses, changes nothing.
    axi_write(BASE + 32'h1C, 32'hCAFEF00D, 4'h0, 2, 0, 0);

    // Out-of-range accesses.
    axi_write(BASE + 4 * NR, 32'h55555555, 4'hF, 0, 0, 1);
    read_chk(BASE + 4 * NR, 0);
    axi_write(BASE - 4, 32'h66666666, 4'hF, 0, 1, 0);
    read_chk(32'hFFFF_FFFC, 0);

    // Read sampled on the same edge the write lands returns the old value.
    d5 = model[0];
    fork
      axi_write(BASE, 32'h000000A5, 4'hF, 0, 0, 0);
      begin
        @(negedge aclk);
        axi_read(BASE, 0, d5, r5);
      end
    join
    chk("t5_old", d5, 32'h0);
    read_chk(BASE, 0);

    // Long backpressure on both channels; new requests meanwhile are ignored.
    fork
      axi_write(BASE + 32'hC, 32'h0BADCAFE, 4'hF, 0, 0, 10);
      read_chk(BASE + 32'h8, 10);
      begin
        repeat (4) @(negedge aclk);
        awaddr = BASE + 32'h18; wdata = 32'h77777777; wstrb = 4'hF; araddr = BASE + 32'h18;
        awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1;
        repeat (5) @(negedge aclk);
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
      end
    join
    chk_regs("t6");
    chk_pulses("t6");

    // Randomized mix.
    for (int it = 0; it < 40; it++) begin
      a = ($urandom_range(0, 9) * 4) + $urandom_range(0, 3);
      if ($urandom_range(0, 9) == 0) a = 32'hFFFF_FFF0 + $urandom_range(0, 15);
      d = $urandom;
      s = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 1) == 1)
        axi_write(a, d, s, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
      else
        read_chk(a, $urandom_range(0, 3));
    end
    chk_regs("rnd");

    // Reset with an address held and data in flight: nothing completes.
    awaddr = BASE + 32'h10; awvalid = 1'b1;
    @(negedge aclk);
    awvalid = 1'b0;
    wdata = 32'h11111111; wstrb = 4'hF; wvalid = 1'b1;
    areset = 1'b1;
    model_reset();
    @(negedge aclk);
    wvalid = 1'b0;
    chk("mid_rst_ready", {awready, wready, arready, bvalid, rvalid}, 5'b00000);
    chk_regs("mid_rst");
    @(negedge aclk);
    areset = 1'b0;
    @(negedge aclk);
    chk("mid_rst_back", {awready, wready, arready}, 3'b111);
    for (int c = 0; c < 4; c++) begin
      @(negedge aclk);
      chk("mid_rst_no_b", {bvalid, rvalid}, 2'b00);
    end
    chk_regs("post_rst");
    chk_pulses("post_rst");
    read_chk(BASE + 32'h10, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
